// File: rtl/keypad_word_buffer.sv
// Keypad word buffer: collects key codes into a word, supports clear/backspace/commit,
// and publishes the committed length plus a live read port into the buffer.
module keypad_word_buffer #(
  parameter int MAX_LEN  = 7,
  parameter int KEY_W    = 4,
  parameter int CNT_W    = 3,
  parameter int SAT_MODE = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             key_valid_i,
  input  logic [KEY_W-1:0] key_code_i,
  input  logic             key_clear_i,
  input  logic             key_back_i,
  input  logic             key_commit_i,
  output logic [CNT_W-1:0] len_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic             word_valid_o,
  output logic [CNT_W-1:0] word_len_o,
  input  logic [CNT_W-1:0] rd_idx_i,
  output logic [KEY_W-1:0] rd_data_o
);
  localparam logic [CNT_W-1:0] MaxC = CNT_W'(MAX_LEN);

  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             wv_q, wv_d;
  logic [CNT_W-1:0] wlen_q, wlen_d;
  logic [KEY_W-1:0] kbuf_q [MAX_LEN];
  logic [KEY_W-1:0] kbuf_d [MAX_LEN];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      len_q  <= '0;
      ovf_q  <= 1'b0;
      wv_q   <= 1'b0;
      wlen_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) kbuf_q[i] <= '0;
    end else begin
      len_q  <= len_d;
      ovf_q  <= ovf_d;
      wv_q   <= wv_d;
      wlen_q <= wlen_d;
      for (int i = 0; i < MAX_LEN; i++) kbuf_q[i] <= kbuf_d[i];
    end
  end

  // One action per cycle; the if/else chain encodes the strobe priority.
  always_comb begin
    len_d  = len_q;
    ovf_d  = ovf_q;
    wv_d   = 1'b0;
    wlen_d = wlen_q;
    for (int i = 0; i < MAX_LEN; i++) kbuf_d[i] = kbuf_q[i];
    if (key_clear_i) begin
      len_d = '0;
      ovf_d = 1'b0;
    end else if (key_commit_i) begin
      if (len_q != '0) begin
        wlen_d = len_q;
        wv_d   = 1'b1;
        len_d  = '0;
        ovf_d  = 1'b0;
      end
    end else if (key_back_i) begin
      if (len_q != '0) len_d = len_q - 1'b1;
    end else if (key_valid_i) begin
      if (len_q < MaxC) begin
        for (int i = 0; i < MAX_LEN; i++)
          if (len_q == CNT_W'(i)) kbuf_d[i] = key_code_i;
        len_d = len_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (SAT_MODE == 0) begin
          kbuf_d[0] = key_code_i;
          len_d     = CNT_W'(1);
        end
      end
    end
  end

  // Mux-style read so indices at or beyond MAX_LEN return zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (rd_idx_i == CNT_W'(i)) rd_data_o = kbuf_q[i];
  end

  assign len_o        = len_q;
  assign full_o       = (len_q == MaxC);
  assign overflow_o   = ovf_q;
  assign word_valid_o = wv_q;
  assign word_len_o   = wlen_q;
endmodule

// File: tb/tb_keypad_word_buffer.sv
// Bench: saturating (s=1) and wrapping (s=0) instances share stimulus; each is checked
// against a per-mode reference model of the word buffer after every cycle.
module tb_keypad_word_buffer;
  localparam int ML = 7;

  logic clk = 1'b0, reset = 1'b1;
  logic kv = 1'b0, kc = 1'b0, kb = 1'b0, kcm = 1'b0;
  logic [3:0] code = '0;
  logic [2:0] rd_idx = '0;
  logic [1:0][2:0] len_w, wlen_w;
  logic [1:0] full_w, ovf_w, wv_w;
  logic [1:0][3:0] rd_w;

  int tests = 0, fails = 0;

  // Reference state per mode: index 1 = saturate, 0 = wrap.
  int m_len[2], m_wlen[2];
  bit m_ovf[2], m_wv[2];
  int m_buf[2][ML];

  always #10 clk = ~clk;

  for (genvar s = 0; s < 2; s++) begin : g_dut
    keypad_word_buffer #(.MAX_LEN(ML), .KEY_W(4), .CNT_W(3), .SAT_MODE(s)) dut (
      .clk_i(clk), .reset_i(reset), .key_valid_i(kv), .key_code_i(code),
      .key_clear_i(kc), .key_back_i(kb), .key_commit_i(kcm),
      .len_o(len_w[s]), .full_o(full_w[s]), .overflow_o(ovf_w[s]),
      .word_valid_o(wv_w[s]), .word_len_o(wlen_w[s]),
      .rd_idx_i(rd_idx), .rd_data_o(rd_w[s]));
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_len[s] = 0; m_wlen[s] = 0; m_ovf[s] = 0; m_wv[s] = 0;
      for (int i = 0; i < ML; i++) m_buf[s][i] = 0;
    end
  endtask

  task automatic model_step(input bit v, input int c, input bit clr, input bit bk, input bit com);
    for (int s = 0; s < 2; s++) begin
      m_wv[s] = 0;
      if (clr) begin
        m_len[s] = 0; m_ovf[s] = 0;
      end else if (com) begin
        if (m_len[s] > 0) begin
          m_wlen[s] = m_len[s]; m_wv[s] = 1; m_len[s] = 0; m_ovf[s] = 0;
        end
      end else if (bk) begin
        if (m_len[s] > 0) m_len[s]--;
      end else if (v) begin
        if (m_len[s] < ML) begin
          m_buf[s][m_len[s]] = c; m_len[s]++;
        end else begin
          m_ovf[s] = 1;
          if (s == 0) begin m_buf[s][0] = c; m_len[s] = 1; end
        end
      end
    end
  endtask

  // Compare every output of both instances, sweeping rd_idx over all 8 codes.
  task automatic check_all(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s.len%0d", tag, s), int'(len_w[s]), m_len[s]);
      chk($sformatf("%s.full%0d", tag, s), int'(full_w[s]), int'(m_len[s] == ML));
      chk($sformatf("%s.ovf%0d", tag, s), int'(ovf_w[s]), int'(m_ovf[s]));
      chk($sformatf("%s.wv%0d", tag, s), int'(wv_w[s]), int'(m_wv[s]));
      chk($sformatf("%s.wlen%0d", tag, s), int'(wlen_w[s]), m_wlen[s]);
    end
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      for (int s = 0; s < 2; s++)
        chk($sformatf("%s.rd%0d[%0d]", tag, s, i), int'(rd_w[s]), (i < ML) ? m_buf[s][i] : 0);
    end
  endtask

  // Drive strobes for one clock edge, then check shortly after the edge.
  task automatic step(input string tag, input bit v, input int c, input bit clr,
                      input bit bk, input bit com);
    kv = v; code = 4'(c); kc = clr; kb = bk; kcm = com;
    @(posedge clk);
    #1;
    kv = 0; kc = 0; kb = 0; kcm = 0;
    model_step(v, c, clr, bk, com);
    check_all(tag);
  endtask

  task automatic key(input string tag, input int c);
    step(tag, 1, c, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // 1: basic word
    key("t1k3", 3); chk("t1.len1", int'(len_w[1]), 1);
    key("t1k1", 1); chk("t1.len2", int'(len_w[1]), 2);
    key("t1k4", 4); chk("t1.len3", int'(len_w[1]), 3);
    step("t1cm", 0, 0, 0, 0, 1);
    chk("t1.wv", int'(wv_w[1]), 1);
    chk("t1.wlen", int'(word_len_const(wlen_w[1])), 3);
    step("t1idle", 0, 0, 0, 0, 0);
    chk("t1.wv_drop", int'(wv_w[1]), 0);

    // 2/3: eight keys, 8th = 0xA; saturate holds 7, wrap restarts at 1
    for (int i = 0; i < 7; i++) key("t23k", $urandom_range(0, 15));
    key("t23k8", 4'hA);
    chk("t2.len", int'(len_w[1]), 7);
    chk("t2.full", int'(full_w[1]), 1);
    chk("t2.ovf", int'(ovf_w[1]), 1);
    chk("t3.len", int'(len_w[0]), 1);
    chk("t3.ovf", int'(ovf_w[0]), 1);
    step("t2cm", 0, 0, 0, 0, 1);
    chk("t2.wlen", int'(wlen_w[1]), 7);
    chk("t2.ovf_clr", int'(ovf_w[1]), 0);

    // 4: backspace to and past empty, then empty commit
    step("t4clr", 0, 0, 1, 0, 0);
    key("t4k5", 5); key("t4k6", 6);
    step("t4b1", 0, 0, 0, 1, 0);
    step("t4b2", 0, 0, 0, 1, 0);
    step("t4b3", 0, 0, 0, 1, 0);
    step("t4cm0", 0, 0, 0, 0, 1);
    chk("t4.nowv", int'(wv_w[1]), 0);

    // 5: priority among simultaneous strobes
    for (int i = 0; i < 4; i++) key("t5k", i + 8);
    step("t5all", 1, 9, 1, 0, 1);
    chk("t5.len0", int'(len_w[1]), 0);
    key("t5k", 1); key("t5k", 2);
    step("t5bk", 1, 15, 0, 1, 0);
    chk("t5.len1", int'(len_w[1]), 1);

    // 6: async reset mid-cycle
    step("t6clr", 0, 0, 1, 0, 0);
    key("t6k1", 1); key("t6k2", 2);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t6rst");
    reset = 1'b0;

    // Random traffic, biased toward keys so overflow is exercised
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 99);
      step("rnd", r < 70 || r >= 95, $urandom_range(0, 15),
           r >= 70 && r < 74, (r >= 74 && r < 86) || r >= 97, (r >= 86 && r < 95) || r == 99);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic int word_len_const(input logic [2:0] w);
    return int'(w);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
